// File: rtl/easyaxi_ar_arb_pkg.sv
// -----------------------------------------------------------------------------
// easyaxi_ar_arb_pkg
//   Shared constants and types for the AR-channel arbiter slice.
//   The AXI width defines are guarded, so an earlier easyaxi_define.v that
//   already sets them takes precedence over the fallbacks here.
//   No ports (package).
// -----------------------------------------------------------------------------
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 16
`endif
`ifndef AXI_MST_NUM
`define AXI_MST_NUM 2
`endif
`ifndef AXI_OUTST_MAX
`define AXI_OUTST_MAX 8
`endif

package easyaxi_ar_arb_pkg;

    localparam int ID_W          = `AXI_ID_WIDTH;
    localparam int ADDR_W        = `AXI_ADDR_WIDTH;
    localparam int DEF_MST_NUM   = `AXI_MST_NUM;
    localparam int DEF_OUTST_MAX = `AXI_OUTST_MAX;

    // IDLE: looking for a winner. HOLD: presenting the winner downstream.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } ar_state_e;

endpackage

// File: rtl/easyaxi_ar_arb_if.sv
// -----------------------------------------------------------------------------
// easyaxi_ar_arb_if
//   Bundles the upstream (per-master) AR handshakes and the single downstream
//   AR port.
//   modport master : arbiter side (it is the AXI master of the downstream port
//                    and the acceptor of the upstream requests).
//   modport slave  : environment side (upstream masters + downstream slave).
//   mst_arvalid/arready [MST_NUM]    per-master handshake
//   mst_arid            [MST_NUM*ID] packed IDs, master i in slice i
//   mst_araddr          [MST_NUM*AW] packed addresses
//   slv_arvalid/arready              downstream handshake
//   slv_arid            [ID+SEL_W]   {master index, original ID}
//   slv_araddr          [AW]         downstream address
// -----------------------------------------------------------------------------
interface easyaxi_ar_arb_if
    import easyaxi_ar_arb_pkg::*;
#(
    parameter int MST_NUM = DEF_MST_NUM,
    parameter int SEL_W   = 1
) ();

    logic [MST_NUM-1:0]        mst_arvalid;
    logic [MST_NUM-1:0]        mst_arready;
    logic [MST_NUM*ID_W-1:0]   mst_arid;
    logic [MST_NUM*ADDR_W-1:0] mst_araddr;

    logic                      slv_arvalid;
    logic                      slv_arready;
    logic [ID_W+SEL_W-1:0]     slv_arid;
    logic [ADDR_W-1:0]         slv_araddr;

    modport master (
        input  mst_arvalid, mst_arid, mst_araddr, slv_arready,
        output mst_arready, slv_arvalid, slv_arid, slv_araddr
    );

    modport slave (
        output mst_arvalid, mst_arid, mst_araddr, slv_arready,
        input  mst_arready, slv_arvalid, slv_arid, slv_araddr
    );

endinterface

// File: rtl/easyaxi_rr_pick.sv
// -----------------------------------------------------------------------------
// easyaxi_rr_pick
//   Combinational round-robin pick: first set bit of req searching upward
//   from ptr, wrapping modulo MST_NUM.
//   req     [MST_NUM] request vector
//   ptr     [SEL_W]   highest-priority index this cycle (must be < MST_NUM)
//   gnt_oh  [MST_NUM] one-hot winner (zero when no request)
//   gnt_idx [SEL_W]   binary winner index (zero when no request)
//   any               at least one request present
// -----------------------------------------------------------------------------
module easyaxi_rr_pick #(
    parameter int MST_NUM = 2,
    parameter int SEL_W   = 1
) (
    input  logic [MST_NUM-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [MST_NUM-1:0] gnt_oh,
    output logic [SEL_W-1:0]   gnt_idx,
    output logic               any
);

    logic [MST_NUM-1:0]   mask;
    logic [2*MST_NUM-1:0] dbl;
    logic                 found;

    // Low half holds only requests at or above ptr; high half holds all of
    // them. A plain lowest-bit search over the concatenation then yields the
    // wrapped round-robin winner.
    always_comb begin
        for (int i = 0; i < MST_NUM; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        dbl = {req, req & mask};
    end

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < MST_NUM; i++) begin
            if (!found && dbl[i]) begin
                found      = 1'b1;
                gnt_oh[i]  = 1'b1;
                gnt_idx    = SEL_W'(i);
            end
        end
        for (int i = 0; i < MST_NUM; i++) begin
            if (!found && dbl[i+MST_NUM]) begin
                found      = 1'b1;
                gnt_oh[i]  = 1'b1;
                gnt_idx    = SEL_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/easyaxi_ar_arb.sv
// -----------------------------------------------------------------------------
// easyaxi_ar_arb
//   N-to-1 AXI AR arbiter. Round-robin picks one master, the request is held
//   in a single output register until the downstream slave accepts it, and
//   the master index is prepended to the ID so read data can be routed back.
//   An outstanding-read counter blocks new grants at OUTST_MAX.
//   clk, rst_n       clock, async active-low reset
//   enable           0 blocks new grants (a held request still completes)
//   bus              AR handshakes (see easyaxi_ar_arb_if)
//   rd_done          one pulse per completed read
//   outst_cnt        reads currently in flight
//   err_underflow    sticky: rd_done seen while nothing was in flight
// -----------------------------------------------------------------------------
module easyaxi_ar_arb
    import easyaxi_ar_arb_pkg::*;
#(
    parameter int MST_NUM   = DEF_MST_NUM,
    parameter int SEL_W     = 1,
    parameter int OUTST_MAX = DEF_OUTST_MAX,
    parameter int CNT_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    easyaxi_ar_arb_if.master        bus,
    input  logic                    rd_done,
    output logic [CNT_W-1:0]        outst_cnt,
    output logic                    err_underflow
);

    localparam logic [CNT_W-1:0] OUTST_LIM = CNT_W'(OUTST_MAX);

    typedef struct packed {
        logic [SEL_W-1:0]  idx;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
    } ar_req_t;

    ar_state_e                          state;
    ar_req_t                            held;
    logic                               arvalid_q;
    logic [SEL_W-1:0]                   rr_ptr;

    logic [MST_NUM-1:0][ID_W-1:0]       id_arr;
    logic [MST_NUM-1:0][ADDR_W-1:0]     addr_arr;
    logic [MST_NUM-1:0]                 gnt_oh;
    logic [SEL_W-1:0]                   gnt_idx;
    logic                               any;
    logic                               grant_ok;
    logic                               slv_hs;

    assign id_arr   = bus.mst_arid;
    assign addr_arr = bus.mst_araddr;

    easyaxi_rr_pick #(
        .MST_NUM (MST_NUM),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req     (bus.mst_arvalid),
        .ptr     (rr_ptr),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // grant_ok doubles as the upstream handshake: ready is only raised on a
    // line whose valid is already high. rst_n gating keeps ready low in reset.
    assign grant_ok = rst_n & (state == ST_IDLE) & enable
                    & (outst_cnt < OUTST_LIM) & any;
    assign bus.mst_arready = grant_ok ? gnt_oh : '0;

    assign slv_hs          = arvalid_q & bus.slv_arready;
    assign bus.slv_arvalid = arvalid_q;
    assign bus.slv_arid    = {held.idx, held.id};
    assign bus.slv_araddr  = held.addr;

    // Pointer moves past the winner only once it has left downstream, so a
    // stalled slave cannot cause a master to be skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            held      <= '0;
            arvalid_q <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_ok) begin
                        held.idx  <= gnt_idx;
                        held.id   <= id_arr[gnt_idx];
                        held.addr <= addr_arr[gnt_idx];
                        arvalid_q <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (slv_hs) begin
                        arvalid_q <= 1'b0;
                        rr_ptr    <= (held.idx == SEL_W'(MST_NUM-1)) ? '0
                                                                     : held.idx + 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Grant and completion in one cycle cancel. A completion with nothing
    // in flight leaves the count at zero and latches the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_cnt     <= '0;
            err_underflow <= 1'b0;
        end else if (grant_ok && !rd_done) begin
            outst_cnt <= outst_cnt + 1'b1;
        end else if (rd_done && !grant_ok) begin
            if (outst_cnt == '0) begin
                err_underflow <= 1'b1;
            end else begin
                outst_cnt <= outst_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_easyaxi_ar_arb.sv
module tb_easyaxi_ar_arb;
    import easyaxi_ar_arb_pkg::*;

    localparam int N  = 2;
    localparam int SW = 1;
    localparam int OM = 2;
    localparam int CW = 4;

    typedef struct {
        logic [ID_W+SW-1:0] arid;
        logic [ADDR_W-1:0]  addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic rd_done = 1'b0;
    logic [CW-1:0] cnt_dut;
    logic err_dut;

    easyaxi_ar_arb_if #(.MST_NUM(N), .SEL_W(SW)) bus ();

    easyaxi_ar_arb #(
        .MST_NUM(N), .SEL_W(SW), .OUTST_MAX(OM), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
        .rd_done(rd_done), .outst_cnt(cnt_dut), .err_underflow(err_dut)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // stimulus state
    logic [N-1:0]      vld;
    logic [ID_W-1:0]   rid   [N];
    logic [ADDR_W-1:0] raddr [N];
    bit                auto_done = 0;

    // reference model: busy flag, next-start index, last winner, count
    bit m_busy;
    int m_start, m_last, m_cnt;
    bit m_err;

    exp_t sbq[$];
    int   dut_log[$];
    int   dut_hs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int s);
        for (int k = 0; k < N; k++) if (v[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_start = 0; m_last = 0; m_cnt = 0; m_err = 0;
        sbq.delete();
    endtask

    task automatic drive();
        bus.mst_arvalid = vld;
        for (int i = 0; i < N; i++) begin
            bus.mst_arid[i*ID_W +: ID_W]       = rid[i];
            bus.mst_araddr[i*ADDR_W +: ADDR_W] = raddr[i];
        end
    endtask

    task automatic new_req(input int i);
        vld[i]   = 1'b1;
        rid[i]   = ID_W'($urandom);
        raddr[i] = ADDR_W'($urandom);
    endtask

    // One clock: check DUT against the model at negedge, advance the model,
    // then retire handshaken requests just after the posedge.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int w;
        drive();
        @(negedge clk);
        exp_rdy = '0;
        w = -1;
        if (!rst_n) model_reset();
        else if (!m_busy && enable && m_cnt < OM) begin
            w = pick(vld, m_start);
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        chk("mst_arready", 32'(bus.mst_arready), 32'(exp_rdy));
        chk("slv_arvalid", 32'(bus.slv_arvalid), 32'(m_busy));
        chk("outst_cnt", 32'(cnt_dut), 32'(m_cnt));
        chk("err_underflow", 32'(err_dut), 32'(m_err));
        for (int i = 0; i < N; i++) if (bus.mst_arready[i]) dut_log.push_back(i);
        if (bus.slv_arvalid && bus.slv_arready) dut_hs++;
        if (rst_n) begin
            if (m_busy && bus.slv_arready) begin
                m_busy  = 0;
                m_start = (m_last + 1) % N;
            end
            if (w >= 0) begin
                exp_t e;
                m_busy = 1;
                m_last = w;
                e.arid = {SW'(w), rid[w]};
                e.addr = raddr[w];
                sbq.push_back(e);
            end
            if (rd_done && w < 0) begin
                if (m_cnt == 0) m_err = 1;
                else m_cnt--;
            end else if (!rd_done && w >= 0) begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        if (w >= 0) vld[w] = 1'b0;
        if (auto_done) rd_done = (m_cnt > 0);
    endtask

    // Monitor: whenever the downstream port is valid, it must show the
    // oldest expected request; pop it on the downstream handshake.
    always @(negedge clk) begin
        if (rst_n && bus.slv_arvalid) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected", 32'(bus.slv_arvalid), 32'd0);
            end else begin
                chk("slv_arid", 32'(bus.slv_arid), 32'(sbq[0].arid));
                chk("slv_araddr", 32'(bus.slv_araddr), 32'(sbq[0].addr));
                if (bus.slv_arready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        vld = '0;
        for (int i = 0; i < N; i++) begin rid[i] = '0; raddr[i] = '0; end
        bus.slv_arready = 1'b1;
        model_reset();
        dut_hs = 0;
        drive();

        // reset values
        #1;
        chk("rst_arid", 32'(bus.slv_arid), 32'd0);
        chk("rst_araddr", 32'(bus.slv_araddr), 32'd0);
        step(); step();
        rst_n = 1'b1; enable = 1'b1;
        step();

        // single request from m1
        vld[1] = 1'b1; rid[1] = 4'h3; raddr[1] = 16'h0000;
        step();
        chk("single_valid", 32'(bus.slv_arvalid), 32'd1);
        chk("single_arid", 32'(bus.slv_arid), 32'h13);
        chk("single_cnt", 32'(cnt_dut), 32'd1);
        step();
        rd_done = 1'b1; step(); rd_done = 1'b0;

        // fairness: both masters always requesting
        auto_done = 1;
        dut_log.delete(); dut_hs = 0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) if (!vld[i]) new_req(i);
            step();
        end
        auto_done = 0; rd_done = 1'b0;
        chk("fair_grants", 32'(dut_log.size()), 32'd4);
        if (dut_log.size() >= 4) begin
            chk("fair_o0", 32'(dut_log[0]), 32'd0);
            chk("fair_o1", 32'(dut_log[1]), 32'd1);
            chk("fair_o2", 32'(dut_log[2]), 32'd0);
            chk("fair_o3", 32'(dut_log[3]), 32'd1);
        end
        chk("fair_hs", 32'(dut_hs), 32'd4);
        vld = '0;
        step(); step();

        // backpressure: downstream stalls 5 cycles
        new_req(0);
        bus.slv_arready = 1'b0;
        step();
        dut_hs = 0;
        for (int c = 0; c < 5; c++) step();
        chk("bp_no_hs", 32'(dut_hs), 32'd0);
        bus.slv_arready = 1'b1;
        step();
        chk("bp_hs", 32'(dut_hs), 32'd1);

        // throttle at OUTST_MAX
        rd_done = 1'b1; step(); rd_done = 1'b0;
        dut_log.delete();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) if (!vld[i]) new_req(i);
            step();
        end
        chk("thr_grants", 32'(dut_log.size()), 32'd2);
        chk("thr_cnt", 32'(cnt_dut), 32'd2);
        rd_done = 1'b1; step(); rd_done = 1'b0;
        dut_log.delete();
        for (int c = 0; c < 6; c++) step();
        chk("thr_one_more", 32'(dut_log.size()), 32'd1);

        // simultaneous grant + completion at count 1, then underflow
        rd_done = 1'b1; step();
        chk("sim_pre_cnt", 32'(cnt_dut), 32'd1);
        step();
        chk("sim_cnt", 32'(cnt_dut), 32'd1);
        rd_done = 1'b0;
        step();
        vld = '0;
        step(); step();
        rd_done = 1'b1; step(); step(); rd_done = 1'b0;
        step();
        chk("uf_flag", 32'(err_dut), 32'd1);
        chk("uf_cnt", 32'(cnt_dut), 32'd0);

        // reset in HOLD
        new_req(1);
        bus.slv_arready = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("rst_hold_valid", 32'(bus.slv_arvalid), 32'd0);
        chk("rst_hold_cnt", 32'(cnt_dut), 32'd0);
        model_reset();
        vld = '0;
        step(); step();
        rst_n = 1'b1;
        bus.slv_arready = 1'b1;
        new_req(0); new_req(1);
        dut_log.delete();
        step();
        chk("rst_first_m0", (dut_log.size() > 0) ? 32'(dut_log[0]) : 32'hFF, 32'd0);
        step();
        rd_done = 1'b1; step(); rd_done = 1'b0;

        // enable low blocks new grants
        enable = 1'b0;
        dut_log.delete();
        for (int c = 0; c < 5; c++) step();
        chk("en_blocked", 32'(dut_log.size()), 32'd0);
        enable = 1'b1;

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) if (!vld[i] && ($urandom % 3 != 0)) new_req(i);
            bus.slv_arready = ($urandom % 4 != 0);
            rd_done = (m_cnt > 0) && ($urandom % 3 == 0);
            enable = ($urandom % 8 != 0);
            step();
        end

        // drain
        enable = 1'b0; rd_done = 1'b0; bus.slv_arready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
